// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Optional overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width > 1 ? width : 2);
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow to the next bit.
// Purely combinational.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - Borrow_In, LSB first through one cell; Done pulses WIDTH cycles after accept.
// Start is only taken in IDLE. Define SERIAL_SUB_OVERFLOW_EN to add the signed Overflow_Out port.
import serial_sub_pkg::*;

module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock_In,
  input  logic             Reset_N_In,
  input  logic             Start_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  input  logic             Borrow_In,
  output logic             Ready_Out,
  output logic             Busy_Out,
  output logic             Done_Out,
  output logic [WIDTH-1:0] Difference_Out,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             Overflow_Out,
`endif
  output logic             Borrow_Out
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  sub_bit_cell u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Result fills from the MSB so the first (LSB) bit ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (Start_In) begin
            r_state  <= SHIFT;
            r_a_sh   <= Data_A_In;
            r_b_sh   <= Data_B_In;
            r_borrow <= Borrow_In;
            r_cnt    <= '0;
            r_res    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_a_msb  <= Data_A_In[WIDTH-1];
            r_b_msb  <= Data_B_In[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_diff  <= w_res_next;
            r_bout  <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_ovf   <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign Ready_Out      = r_ready;
  assign Busy_Out       = r_busy;
  assign Done_Out       = r_done;
  assign Difference_Out = r_diff;
  assign Borrow_Out     = r_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign Overflow_Out   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 vector table plus corner sequences, and a WIDTH=1 instance.
// Overflow expectations are checked when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       bin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  logic       s1_start;
  logic       a1_in;
  logic       b1_in;
  logic       bin1;
  logic       ready1;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       bout1;
  logic       ovf1;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .Clock_In       (clk),
    .Reset_N_In     (rst_n),
    .Start_In       (start),
    .Data_A_In      (a_in),
    .Data_B_In      (b_in),
    .Borrow_In      (bin),
    .Ready_Out      (ready),
    .Busy_Out       (busy),
    .Done_Out       (done),
    .Difference_Out (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .Overflow_Out   (ovf),
`endif
    .Borrow_Out     (bout)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut_w1 (
    .Clock_In       (clk),
    .Reset_N_In     (rst_n),
    .Start_In       (s1_start),
    .Data_A_In      (a1_in),
    .Data_B_In      (b1_in),
    .Borrow_In      (bin1),
    .Ready_Out      (ready1),
    .Busy_Out       (busy1),
    .Done_Out       (done1),
    .Difference_Out (diff1),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .Overflow_Out   (ovf1),
`endif
    .Borrow_Out     (bout1)
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] exp_d;
    logic       exp_bo;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full handshake on the WIDTH=8 instance with all result checks.
  task automatic run_check(input vec_t v);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    a_in  = v.a;
    b_in  = v.b;
    bin   = v.bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {30'd0, busy, ready}, 32'b10);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 32'd8);
    chk("difference", {24'd0, diff}, {24'd0, v.exp_d});
    chk("borrow_out", {31'd0, bout}, {31'd0, v.exp_bo});
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("overflow", {31'd0, ovf}, {31'd0, v.exp_ovf});
`endif
    @(posedge clk);
    #1;
    chk("done_pulse_ready", {29'd0, done, busy, ready}, 32'b001);
  endtask

  initial begin
    int dcount;
    int early_ready;
    int lat;
    logic [7:0] first_diff;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin = 1'b0;
    s1_start = 1'b0; a1_in = 1'b0; b1_in = 1'b0; bin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_busy_done", {29'd0, ready, busy, done}, 32'b100);
    chk("reset_diff_borrow", {23'd0, diff, bout}, 32'd0);
    chk("reset_w1", {28'd0, ready1, busy1, done1, diff1}, 32'b1000);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_check(vecs[i]);

    // Reset on the 4th SHIFT edge after a result with borrow=1 is held.
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_ready_busy_done", {29'd0, ready, busy, done}, 32'b100);
    chk("midrst_diff_borrow", {23'd0, diff, bout}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 32'd0);
    run_check('{8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0});

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    a_in = 8'h05; b_in = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcount = 0; early_ready = 0; first_diff = '0;
    for (int c = 0; c < 25; c++) begin
      if (done) begin
        if (dcount == 0) first_diff = diff;
        dcount++;
      end else if (ready && dcount == 0) begin
        early_ready++;
      end
      @(posedge clk);
      #1;
    end
    chk("busy_start_single_done", dcount, 32'd1);
    chk("busy_start_diff", {24'd0, first_diff}, 32'h02);
    chk("busy_start_no_early_ready", early_ready, 32'd0);

    // WIDTH=1 instance: one SHIFT cycle.
    for (int i = 0; i < 3; i++) begin
      logic [2:0] in1;
      logic [1:0] exp1;
      case (i)
        0: begin in1 = 3'b010; exp1 = 2'b11; end
        1: begin in1 = 3'b100; exp1 = 2'b10; end
        default: begin in1 = 3'b111; exp1 = 2'b11; end
      endcase
      @(negedge clk);
      a1_in = in1[2]; b1_in = in1[1]; bin1 = in1[0]; s1_start = 1'b1;
      @(posedge clk);
      #1;
      s1_start = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("w1_latency", lat, 32'd1);
      chk("w1_diff_borrow", {30'd0, diff1, bout1}, {30'd0, exp1});
`ifdef SERIAL_SUB_OVERFLOW_EN
      if (i == 0) chk("w1_overflow", {31'd0, ovf1}, 32'd1);
`endif
      @(posedge clk);
      #1;
      chk("w1_ready_back", {30'd0, done1, ready1}, 32'b01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
